// File: rtl/keypoint_marker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypoint_marker_pkg
// Description : Frame-buffer format constants, the 54-bit SRAM write-command
//               field layout and the keypoint_marker FSM state type. Shared by
//               the image/overlay writers and the SRAM arbiter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package keypoint_marker_pkg;

  // Frame format: 8-bit grayscale, 4 pixels per 32-bit word.
  localparam int IMG_W        = 800;
  localparam int IMG_H        = 600;
  localparam int PIX_PER_WORD = 4;
  localparam int BUF_WORDS    = 120000;

  // Write command layout {mask, addr, data}.
  localparam int CMD_W    = 54;
  localparam int MASK_MSB = 53;
  localparam int MASK_LSB = 50;
  localparam int ADDR_MSB = 49;
  localparam int ADDR_LSB = 32;
  localparam int DATA_MSB = 31;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_DRAW   = 2'd2,
    ST_DONE   = 2'd3
  } km_state_e;

  // Multiply a 10-bit row index by a constant as a sum of shifted copies;
  // with a constant K this folds down to a handful of adders.
  function automatic logic [19:0] mul_by_const(input logic [9:0] a,
                                               input int unsigned k);
    logic [19:0] acc;
    acc = '0;
    for (int b = 0; b < 11; b++) begin
      if (k[b]) acc = acc + (20'(a) << b);
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/marker_offset_gen.sv
`default_nettype none
// ============================================================================
// Module      : marker_offset_gen
// Description : Steps through the plus-marker offsets in drawing order:
//               horizontal arm dx=-ARM..+ARM (dy=0), then the vertical arm
//               dy=-ARM..-1 and dy=+1..+ARM (dx=0). The centre appears once.
//               Wraps back to the first offset after the last one.
// Ports       : clock, reset  - clock, synchronous active-high reset
//               step_i        - advance to the next offset
//               dx_o, dy_o    - current offset, 4-bit two's complement
//               last_o        - current offset is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module marker_offset_gen
  import keypoint_marker_pkg::*;
#(
  parameter int ARM = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step_i,
  output logic [3:0] dx_o,
  output logic [3:0] dy_o,
  output logic       last_o
);

  localparam int NUM_OFF = 4 * ARM + 1;

  logic [4:0] idx_q, idx_d;

  assign last_o = (idx_q == 5'(NUM_OFF - 1));

  always_comb begin
    idx_d = idx_q;
    if (step_i) idx_d = last_o ? 5'd0 : idx_q + 5'd1;
  end

  // Offsets are computed modulo 16; every true value lies within -7..7, so
  // the 4-bit result is the exact two's-complement offset.
  always_comb begin
    dx_o = 4'd0;
    dy_o = 4'd0;
    if (idx_q <= 5'(2 * ARM)) begin
      dx_o = 4'(idx_q) - 4'(ARM);
    end else if (idx_q <= 5'(3 * ARM)) begin
      dy_o = 4'(idx_q) - 4'(3 * ARM + 1);
    end else begin
      dy_o = 4'(idx_q) - 4'(3 * ARM);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) idx_q <= 5'd0;
    else       idx_q <= idx_d;
  end

endmodule
`default_nettype wire

// File: rtl/keypoint_marker.sv
`default_nettype none
// ============================================================================
// Module      : keypoint_marker
// Description : Draws a plus-shaped marker at each incoming keypoint by
//               issuing SRAM byte-masked write commands into the selected
//               frame buffer. Sequenced by a start/done handshake.
// Ports       : clock, reset        - clock, synchronous active-high reset
//               buffer_sel          - target buffer, latched on start accept
//               start / start_ack   - pass request / one-cycle accept pulse
//               done / done_ack     - end-of-pass flag held until acknowledged
//               kp_x, kp_y, kp_last - keypoint coordinates, final-keypoint tag
//               kp_valid / kp_ready - keypoint handshake
//               dout                - {mask[53:50], addr[49:32], data[31:0]}
//               valid / ready       - write command handshake
// Revision    : 1.0 - initial release
// ============================================================================
module keypoint_marker
  import keypoint_marker_pkg::*;
#(
  parameter int       IMG_W      = keypoint_marker_pkg::IMG_W,
  parameter int       IMG_H      = keypoint_marker_pkg::IMG_H,
  parameter int       BUF_WORDS  = keypoint_marker_pkg::BUF_WORDS,
  parameter int       ARM        = 2,
  parameter logic [7:0] MARK_VALUE = 8'hFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        buffer_sel,
  input  logic        start,
  output logic        start_ack,
  output logic        done,
  input  logic        done_ack,
  input  logic [9:0]  kp_x,
  input  logic [9:0]  kp_y,
  input  logic        kp_last,
  input  logic        kp_valid,
  output logic        kp_ready,
  output logic [53:0] dout,
  output logic        valid,
  input  logic        ready
);

  km_state_e   state_q, state_d;
  logic        buf_q, buf_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic [53:0] dout_q, dout_d;

  logic        step;
  logic [3:0]  off_dx, off_dy;
  logic        off_last;

  marker_offset_gen #(
    .ARM (ARM)
  ) u_offset_gen (
    .clock  (clock),
    .reset  (reset),
    .step_i (step),
    .dx_o   (off_dx),
    .dy_o   (off_dy),
    .last_o (off_last)
  );

  // Pixel position in 12-bit two's complement; bit 11 flags a negative value.
  logic [11:0] px, py;
  logic        clip;
  logic [19:0] pix;
  logic [17:0] addr;
  logic [3:0]  mask;
  logic        out_free;

  assign px   = {2'b00, x_q} + {{8{off_dx[3]}}, off_dx};
  assign py   = {2'b00, y_q} + {{8{off_dy[3]}}, off_dy};
  assign clip = px[11] | py[11] | (px >= 12'(IMG_W)) | (py >= 12'(IMG_H));
  assign pix  = mul_by_const(py[9:0], IMG_W) + {10'd0, px[9:0]};
  assign addr = 18'(pix >> 2) + (buf_q ? 18'(BUF_WORDS) : 18'd0);
  assign mask = 4'b0001 << pix[1:0];

  // The output register can take a new command if it is empty or its
  // current command is being consumed this cycle.
  assign out_free = ~valid_q | ready;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    x_d       = x_q;
    y_d       = y_q;
    last_d    = last_q;
    valid_d   = valid_q & ~ready;
    dout_d    = dout_q;
    start_ack = 1'b0;
    kp_ready  = 1'b0;
    done      = 1'b0;
    step      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_ack = 1'b1;
          buf_d     = buffer_sel;
          state_d   = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        kp_ready = 1'b1;
        if (kp_valid) begin
          x_d     = kp_x;
          y_d     = kp_y;
          last_d  = kp_last;
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        // Clipped offsets still wait for a free output slot so that the
        // offset sequence advances at one step per usable cycle.
        if (out_free) begin
          step = 1'b1;
          if (!clip) begin
            valid_d                   = 1'b1;
            dout_d[MASK_MSB:MASK_LSB] = mask;
            dout_d[ADDR_MSB:ADDR_LSB] = addr;
            dout_d[DATA_MSB:DATA_LSB] = {4{MARK_VALUE}};
          end
          if (off_last) state_d = last_q ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_DONE: begin
        // Signal completion only after the final write has left.
        done = ~valid_q;
        if (done && done_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      buf_q   <= 1'b0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= 54'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      x_q     <= x_d;
      y_q     <= y_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_keypoint_marker.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypoint_marker
// Description : Self-checking bench for keypoint_marker: hand-computed vector
//               table, directed multi-cycle sequences and randomized passes
//               compared against a pixel-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypoint_marker;

  localparam int TB_W   = 800;
  localparam int TB_H   = 600;
  localparam int TB_BUF = 120000;
  localparam int TB_ARM = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        buffer_sel = 1'b0;
  logic        start = 1'b0;
  logic        start_ack;
  logic        done;
  logic        done_ack = 1'b0;
  logic [9:0]  kp_x = 10'd0;
  logic [9:0]  kp_y = 10'd0;
  logic        kp_last = 1'b0;
  logic        kp_valid = 1'b0;
  logic        kp_ready;
  logic [53:0] dout;
  logic        valid;
  logic        ready = 1'b1;

  keypoint_marker dut (
    .clock      (clock),
    .reset      (reset),
    .buffer_sel (buffer_sel),
    .start      (start),
    .start_ack  (start_ack),
    .done       (done),
    .done_ack   (done_ack),
    .kp_x       (kp_x),
    .kp_y       (kp_y),
    .kp_last    (kp_last),
    .kp_valid   (kp_valid),
    .kp_ready   (kp_ready),
    .dout       (dout),
    .valid      (valid),
    .ready      (ready)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [53:0] got[$];
  logic [53:0] exp_q[$];
  int          kx[$];
  int          ky[$];

  logic        mon_en     = 1'b0;
  logic        prev_stall = 1'b0;
  logic [53:0] prev_dout  = '0;
  int          rdy_mode   = 0;   // 0: bench holds ready, 1: random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Output monitor: a command is transferred at the posedge following a
  // negedge where valid&ready; a stalled command must stay put.
  initial forever begin
    @(negedge clock);
    if (mon_en) begin
      if (prev_stall) begin
        check("stall_valid", 64'(valid), 64'd1);
        check("stall_dout", 64'(dout), 64'(prev_dout));
      end
      if (valid && ready) got.push_back(dout);
      prev_stall = valid && !ready;
      prev_dout  = dout;
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (rdy_mode == 1) ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- reference model ----------------
  function automatic void add_px(input logic b, input int px, input int py);
    int p;
    if (px < 0 || px >= TB_W || py < 0 || py >= TB_H) return;
    p = py * TB_W + px;
    exp_q.push_back({4'(1 << (p % 4)), 18'(p / 4 + (b ? TB_BUF : 0)), 32'hFFFF_FFFF});
  endfunction

  function automatic void model(input logic b);
    for (int k = 0; k < kx.size(); k++) begin
      for (int d = -TB_ARM; d <= TB_ARM; d++) add_px(b, kx[k] + d, ky[k]);
      for (int d = -TB_ARM; d <= TB_ARM; d++) if (d != 0) add_px(b, kx[k], ky[k] + d);
    end
  endfunction

  task automatic compare_writes(input string name);
    check({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check({name, "_write"}, 64'(got[i]), 64'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input logic b);
    logic seen;
    seen = 1'b0;
    @(posedge clock); #1;
    buffer_sel = b;
    start      = 1'b1;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clock);
      if (start_ack) seen = 1'b1;
    end
    check("start_ack", 64'(seen), 64'd1);
    @(posedge clock); #1;
    buffer_sel = ~b;          // latched value must be the one at acceptance
    @(negedge clock);
    check("start_ignored", 64'(start_ack), 64'd0);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_kp(input int x, input int y, input logic lst);
    logic acc;
    acc = 1'b0;
    kp_x = 10'(x); kp_y = 10'(y); kp_last = lst; kp_valid = 1'b1;
    for (int t = 0; t < 3000 && !acc; t++) begin
      @(negedge clock);
      if (kp_ready) acc = 1'b1;
    end
    check("kp_accept", 64'(acc), 64'd1);
    @(posedge clock); #1;
    kp_valid = 1'b0;
    if (acc) begin
      @(negedge clock);
      check("kp_ready_drop", 64'(kp_ready), 64'd0);
    end
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 5000 && !seen; t++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    repeat (2) @(negedge clock);
    check("done_hold", 64'(done), 64'd1);
    @(posedge clock); #1; done_ack = 1'b1;
    @(posedge clock); #1; done_ack = 1'b0;
    @(negedge clock);
    check("done_clear", 64'(done), 64'd0);
  endtask

  task automatic run_pass(input logic b);
    do_start(b);
    for (int i = 0; i < kx.size(); i++) begin
      send_kp(kx[i], ky[i], i == kx.size() - 1);
      if (rdy_mode == 1) repeat ($urandom_range(0, 3)) @(posedge clock);
    end
    wait_done();
    model(b);
  endtask

  typedef struct {
    logic       b;
    int         x;
    int         y;
    int         cnt;
    logic [3:0] fm;
    int         fa;
    logic [3:0] lm;
    int         la;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic seen;
    tbl[0] = '{1'b0, 100,  50,  9, 4'b0100, 10024,  4'b0001, 10425};
    tbl[1] = '{1'b1,   0,   0,  5, 4'b0001, 120000, 4'b0001, 120400};
    tbl[2] = '{1'b0, 799, 599,  5, 4'b0010, 119999, 4'b1000, 119799};
    tbl[3] = '{1'b0, 1023, 1023, 0, 4'b0000, 0,     4'b0000, 0};
    tbl[4] = '{1'b1,   1,   1,  7, 4'b0001, 120200, 4'b0010, 120600};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_start_ack", 64'(start_ack), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_kp_ready", 64'(kp_ready), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    @(posedge clock); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Table of single-keypoint passes with hand-computed endpoints
    for (int i = 0; i < 5; i++) begin
      kx = {tbl[i].x};
      ky = {tbl[i].y};
      run_pass(tbl[i].b);
      check("tbl_count", 64'(got.size()), 64'(tbl[i].cnt));
      if (tbl[i].cnt > 0 && got.size() > 0) begin
        check("tbl_first", 64'(got[0][53:32]), 64'({tbl[i].fm, 18'(tbl[i].fa)}));
        check("tbl_last", 64'(got[got.size()-1][53:32]), 64'({tbl[i].lm, 18'(tbl[i].la)}));
        check("tbl_data", 64'(got[0][31:0]), 64'hFFFF_FFFF);
      end
      compare_writes("tbl");
    end

    // Centre pixel of the normal marker (third write)
    kx = {100}; ky = {50};
    run_pass(1'b0);
    if (got.size() > 2) check("centre", 64'(got[2][53:32]), 64'({4'b0001, 18'd10025}));
    else check("centre_present", 64'(got.size()), 64'd9);
    compare_writes("centre");

    // Backpressure: two 5-cycle stalls with a command pending
    ready = 1'b0;
    kx = {100}; ky = {50};
    do_start(1'b0);
    send_kp(100, 50, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clock);
      if (valid) seen = 1'b1;
    end
    check("bp_valid", 64'(seen), 64'd1);
    repeat (5) @(posedge clock);
    #1; ready = 1'b1;
    for (int t = 0; t < 50 && got.size() < 4; t++) @(negedge clock);
    @(posedge clock); #1; ready = 1'b0;
    repeat (5) @(posedge clock);
    #1; ready = 1'b1;
    wait_done();
    model(1'b0);
    compare_writes("bp");

    // Multi-keypoint with sentinel terminator
    kx = {10, 1023}; ky = {10, 1023};
    run_pass(1'b0);
    compare_writes("multi");

    // Randomized passes with random backpressure
    rdy_mode = 1;
    for (int r = 0; r < 8; r++) begin
      int n;
      logic b;
      n = $urandom_range(1, 4);
      b = 1'($urandom_range(0, 1));
      kx.delete(); ky.delete();
      for (int k = 0; k < n; k++) begin
        kx.push_back(($urandom_range(0, 9) == 0) ? 1023 : $urandom_range(0, 805));
        ky.push_back(($urandom_range(0, 9) == 0) ? 1023 : $urandom_range(0, 605));
      end
      run_pass(b);
      compare_writes("rand");
    end
    rdy_mode = 0;
    @(posedge clock); #1; ready = 1'b1;

    // Reset in the middle of a pass
    do_start(1'b0);
    kp_x = 10'd100; kp_y = 10'd50; kp_last = 1'b1; kp_valid = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clock);
      if (kp_ready) seen = 1'b1;
    end
    @(posedge clock); #1; kp_valid = 1'b0;
    for (int t = 0; t < 50 && got.size() < 3; t++) @(negedge clock);
    check("rst_mid_writes", 64'(got.size()), 64'd3);
    @(posedge clock); #1;
    reset = 1'b1; ready = 1'b0; mon_en = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid_valid", 64'(valid), 64'd0);
    check("rst_mid_kp_ready", 64'(kp_ready), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    got.delete();
    prev_stall = 1'b0;
    ready  = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge clock);
    check("rst_mid_silent", 64'(got.size()), 64'd0);
    check("rst_mid_idle_valid", 64'(valid), 64'd0);

    // Recovery after reset
    kx = {0}; ky = {0};
    run_pass(1'b1);
    compare_writes("recover");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
